// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the pattern scan controller.
package pattern_scan_ctrl_pkg;

  localparam int FRAME_W = 25;  // default max frame bits per scan
  localparam int CNT_W   = 3;   // default hit-counter width
  localparam int LEN_W   = 5;   // width of the frame-length field

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_LOAD   = 3'b001,
    ST_SHIFT  = 3'b010,
    ST_DRAIN  = 3'b011,
    ST_REPORT = 3'b100
  } state_e;

  // Limit a requested length to the physical frame width.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                  input logic [LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Request/response bundle between a frame requester/detector and the controller.
interface pattern_scan_ctrl_if #(
  parameter int FRAME_W = pattern_scan_ctrl_pkg::FRAME_W,
  parameter int CNT_W   = pattern_scan_ctrl_pkg::CNT_W
);
  logic                                  START;
  logic [FRAME_W-1:0]                    FRAME_IN;
  logic [pattern_scan_ctrl_pkg::LEN_W-1:0] FRAME_LEN;
  logic [CNT_W-1:0]                      THRESH;
  logic                                  DET_HIT;
  logic                                  X_OUT;
  logic                                  DET_RST;
  logic                                  READY;
  logic [CNT_W-1:0]                      HIT_CNT;
  logic                                  ALARM;
  logic                                  DONE;

  // Requester side: issues frames and plays the external detector.
  modport master (
    output START, FRAME_IN, FRAME_LEN, THRESH, DET_HIT,
    input  X_OUT, DET_RST, READY, HIT_CNT, ALARM, DONE
  );

  // Controller side.
  modport slave (
    input  START, FRAME_IN, FRAME_LEN, THRESH, DET_HIT,
    output X_OUT, DET_RST, READY, HIT_CNT, ALARM, DONE
  );
endinterface

// File: rtl/pattern_scan_shreg.sv
// Frame shift register (MSB out first) with a bit down-counter.
module pattern_scan_shreg
  import pattern_scan_ctrl_pkg::LEN_W;
#(
  parameter int FRAME_W = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_shift_en,
  output logic               o_ser,
  output logic               o_last,
  output logic               o_empty
);

  logic [FRAME_W-1:0] r_shreg;
  logic [LEN_W-1:0]   r_cnt;

  // Load a new frame, or shift one bit out per enabled cycle while bits remain.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shreg <= i_frame;
      r_cnt   <= i_len;
    end else if (i_shift_en && (r_cnt != '0)) begin
      r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
      r_cnt   <= r_cnt - LEN_W'(1);
    end
  end

  assign o_ser   = r_shreg[FRAME_W-1];
  assign o_last  = (r_cnt == LEN_W'(1));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Serialises a frame into an external sequence detector, counts its hits and
// reports a threshold alarm once the frame has fully drained.
module pattern_scan_ctrl #(
  parameter int FRAME_W = pattern_scan_ctrl_pkg::FRAME_W,
  parameter int CNT_W   = pattern_scan_ctrl_pkg::CNT_W
) (
  input logic                   CLK,
  input logic                   RST,
  pattern_scan_ctrl_if.slave    bus
);
  import pattern_scan_ctrl_pkg::*;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_hit_cnt;
  logic [CNT_W-1:0]   w_hit_cnt_nxt;
  logic [CNT_W-1:0]   r_thresh;
  logic               r_alarm;
  logic               w_accept;
  logic               w_ser;
  logic               w_last;
  logic               w_empty;
  logic [LEN_W-1:0]   w_len_clamped;
  logic               w_ready;
  logic               w_det_rst;
  logic               w_done;
  logic               w_x_out;

  assign w_accept      = (r_state == ST_IDLE) && bus.START;
  assign w_len_clamped = clamp_len(bus.FRAME_LEN, LEN_W'(FRAME_W));

  pattern_scan_shreg #(.FRAME_W(FRAME_W)) u_shreg (
    .clk        (CLK),
    .rst        (RST),
    .i_load     (w_accept),
    .i_frame    (bus.FRAME_IN),
    .i_len      (w_len_clamped),
    .i_shift_en (r_state == ST_SHIFT),
    .o_ser      (w_ser),
    .o_last     (w_last),
    .o_empty    (w_empty)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; a zero-length frame skips SHIFT entirely.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.START) w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = w_empty ? ST_DRAIN : ST_SHIFT;
      ST_SHIFT:  if (w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  w_state_nxt = ST_REPORT;
      ST_REPORT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register (plus registered data bit).
  always_comb begin
    w_ready   = 1'b0;
    w_det_rst = 1'b1;
    w_done    = 1'b0;
    w_x_out   = 1'b0;
    case (r_state)
      ST_IDLE:   w_ready = 1'b1;
      ST_SHIFT: begin
        w_det_rst = 1'b0;
        w_x_out   = w_ser;
      end
      ST_DRAIN:  w_det_rst = 1'b0;
      ST_REPORT: w_done = 1'b1;
      default:   ;
    endcase
  end

  // Saturating increment for a hit sampled this cycle.
  assign w_hit_cnt_nxt = (bus.DET_HIT && (r_hit_cnt != {CNT_W{1'b1}}))
                       ? r_hit_cnt + CNT_W'(1) : r_hit_cnt;

  // Hit counting, threshold capture and alarm evaluation on entry to REPORT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hit_cnt <= '0;
      r_thresh  <= '0;
      r_alarm   <= 1'b0;
    end else if (w_accept) begin
      r_hit_cnt <= '0;
      r_thresh  <= bus.THRESH;
      r_alarm   <= 1'b0;
    end else begin
      if ((r_state == ST_SHIFT) || (r_state == ST_DRAIN)) r_hit_cnt <= w_hit_cnt_nxt;
      // Includes the detector's response to the last bit, seen during DRAIN.
      if (r_state == ST_DRAIN) r_alarm <= (w_hit_cnt_nxt >= r_thresh);
    end
  end

  assign bus.READY   = w_ready;
  assign bus.DET_RST = w_det_rst;
  assign bus.DONE    = w_done;
  assign bus.X_OUT   = w_x_out;
  assign bus.HIT_CNT = r_hit_cnt;
  assign bus.ALARM   = r_alarm;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl with a 1001 overlapping detector model.
module tb_pattern_scan_ctrl;
  localparam int FW = 25;
  localparam int CW = 3;

  typedef struct {
    string name;
    int    cnt;
    int    alarm;
    int    done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;
  logic [3:0] det_hist;
  exp_t sb_q[$];

  localparam logic [FW-1:0] FRAME_A = 25'b1001_0011_0010_0001_0010_0100_1;
  localparam logic [FW-1:0] FRAME_B = 25'b1001_0010_0100_1001_0010_0100_1;

  pattern_scan_ctrl_if #(.FRAME_W(FW), .CNT_W(CW)) bus ();

  pattern_scan_ctrl #(.FRAME_W(FW), .CNT_W(CW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External detector: registered 1001 overlapping match, held clear by DET_RST.
  always @(posedge clk) begin
    if (bus.DET_RST) begin
      det_hist    <= 4'b0000;
      bus.DET_HIT <= 1'b0;
    end else begin
      det_hist    <= {det_hist[2:0], bus.X_OUT};
      bus.DET_HIT <= ({det_hist[2:0], bus.X_OUT} == 4'b1001);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.DONE) begin
      exp_t e;
      check("done_one_cycle", prev_done, 0);
      check("done_expected", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.name, "_hit_cnt"}, bus.HIT_CNT, e.cnt);
        check({e.name, "_alarm"},   bus.ALARM,   e.alarm);
        check({e.name, "_latency"}, cyc,         e.done_cyc);
      end
    end
    prev_done = bus.DONE;
  end

  // Issue one START; when expected, queue the hand-computed outcome.
  task automatic start_frame(input string name, input logic [FW-1:0] frame,
                             input logic [4:0] len, input logic [CW-1:0] th,
                             input bit expect_done, input int exp_cnt,
                             input int exp_alarm, input int exp_lat);
    exp_t e;
    @(negedge clk);
    bus.START     = 1'b1;
    bus.FRAME_IN  = frame;
    bus.FRAME_LEN = len;
    bus.THRESH    = th;
    @(posedge clk);
    @(negedge clk);
    bus.START = 1'b0;
    if (expect_done) begin
      e.name = name; e.cnt = exp_cnt; e.alarm = exp_alarm; e.done_cyc = cyc + exp_lat;
      sb_q.push_back(e);
    end
  endtask

  // Bounded wait for all queued frames to report, then verify held results.
  task automatic finish_frame(input string name, input int exp_cnt, input int exp_alarm);
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_reported"}, sb_q.size(), 0);
    repeat (3) @(negedge clk);
    check({name, "_hold_cnt"},   bus.HIT_CNT, exp_cnt);
    check({name, "_hold_alarm"}, bus.ALARM,   exp_alarm);
    check({name, "_idle_ready"}, bus.READY,   1);
    check({name, "_idle_xout"},  bus.X_OUT,   0);
  endtask

  initial begin
    bus.START     = 1'b0;
    bus.FRAME_IN  = '0;
    bus.FRAME_LEN = '0;
    bus.THRESH    = '0;

    repeat (3) @(negedge clk);
    check("rst_ready",   bus.READY,   1);
    check("rst_det_rst", bus.DET_RST, 1);
    check("rst_xout",    bus.X_OUT,   0);
    check("rst_hit_cnt", bus.HIT_CNT, 0);
    check("rst_alarm",   bus.ALARM,   0);
    check("rst_done",    bus.DONE,    0);
    rst = 1'b0;

    // Full frame, six overlapping hits, last one seen in DRAIN.
    start_frame("full25", FRAME_A, 5'd25, 3'd3, 1'b1, 6, 1, 27);
    finish_frame("full25", 6, 1);

    // Short frame clears previous results on START; the single hit arrives in DRAIN.
    start_frame("len4", FRAME_A, 5'd4, 3'd2, 1'b1, 1, 0, 6);
    check("start_clears_cnt",   bus.HIT_CNT, 0);
    check("start_clears_alarm", bus.ALARM,   0);
    check("load_ready_low",     bus.READY,   0);
    finish_frame("len4", 1, 0);

    // Eight hits saturate the 3-bit counter at 7.
    start_frame("sat", FRAME_B, 5'd25, 3'd7, 1'b1, 7, 1, 27);
    finish_frame("sat", 7, 1);

    // Zero-length frame with zero threshold: no hits, alarm still set.
    start_frame("len0", FRAME_A, 5'd0, 3'd0, 1'b1, 0, 1, 2);
    finish_frame("len0", 0, 1);

    // Over-long length clamps to the frame width.
    start_frame("clamp", FRAME_A, 5'd31, 3'd6, 1'b1, 6, 1, 27);
    finish_frame("clamp", 6, 1);

    // START pulsed mid-SHIFT is ignored: exactly one DONE.
    start_frame("busy", FRAME_B, 5'd10, 3'd3, 1'b1, 3, 1, 12);
    repeat (4) @(negedge clk);
    bus.START = 1'b1;
    check("busy_ready_low", bus.READY, 0);
    @(negedge clk);
    bus.START = 1'b0;
    finish_frame("busy", 3, 1);
    repeat (30) @(negedge clk);

    // Asynchronous reset in the middle of SHIFT abandons the frame.
    start_frame("abort", FRAME_A, 5'd25, 3'd3, 1'b0, 0, 0, 0);
    repeat (8) @(negedge clk);
    check("abort_in_shift", bus.DET_RST, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_det_rst", bus.DET_RST, 1);
    check("abort_xout",    bus.X_OUT,   0);
    check("abort_hit_cnt", bus.HIT_CNT, 0);
    check("abort_ready",   bus.READY,   1);
    check("abort_done",    bus.DONE,    0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Normal operation after the aborted frame.
    start_frame("resume", FRAME_A, 5'd25, 3'd3, 1'b1, 6, 1, 27);
    finish_frame("resume", 6, 1);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter FRAME_W, default 25, max frame bits per scan.
REQ-002 SHALL have parameter CNT_W, default 3, hit-counter width.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port START  input  1  frame request, sampled only in IDLE.
REQ-006 SHALL have port FRAME_IN  input  FRAME_W  frame bits; FRAME_IN[FRAME_W-1] is sent first.
REQ-007 SHALL have port FRAME_LEN  input  5  number of bits to send.
REQ-008 SHALL have port THRESH  input  CNT_W  alarm threshold.
REQ-009 SHALL have port DET_HIT  input  1  registered hit flag from the external sequence detector.
REQ-010 SHALL have port X_OUT  output  1  serial bit to the detector.
REQ-011 SHALL have port DET_RST  output  1  detector reset.
REQ-012 SHALL have port READY  output  1  high in IDLE only.
REQ-013 SHALL have port HIT_CNT  output  CNT_W  hits counted in the current or last frame.
REQ-014 SHALL have port ALARM  output  1  HIT_CNT >= THRESH for the last completed frame.
REQ-015 SHALL have port DONE  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement Moore FSM states IDLE, LOAD, SHIFT, DRAIN, REPORT; all outputs registered or decoded from the state register only.
REQ-017 IDLE: START=1 at posedge SHALL latch FRAME_IN, clamped FRAME_LEN and THRESH; clear HIT_CNT and ALARM; next state LOAD.
REQ-018 FRAME_LEN > FRAME_W SHALL clamp to FRAME_W; FRAME_LEN = 0 SHALL go LOAD -> DRAIN with no SHIFT cycles.
REQ-019 LOAD SHALL last exactly one cycle; next state SHIFT (or DRAIN if length 0).
REQ-020 SHIFT SHALL present one frame bit on X_OUT per cycle, MSB first, for exactly FRAME_LEN cycles, then go to DRAIN.
REQ-021 DRAIN SHALL last one cycle, so the detector's registered response to the last bit is sampled; next state REPORT.
REQ-022 REPORT SHALL assert DONE for exactly one cycle; next state IDLE.
REQ-023 DET_RST SHALL be 1 in IDLE, LOAD and REPORT, and 0 in SHIFT and DRAIN.
REQ-024 X_OUT SHALL be 0 outside SHIFT.
REQ-025 HIT_CNT SHALL increment on each posedge in SHIFT or DRAIN with DET_HIT=1, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-026 ALARM SHALL be registered on entry to REPORT as (HIT_CNT >= THRESH), where HIT_CNT includes any hit sampled in DRAIN, and held until the next accepted START; THRESH=0 SHALL always give ALARM=1.
REQ-027 HIT_CNT SHALL hold its final value after REPORT until the next accepted START.
REQ-028 START outside IDLE SHALL be ignored, with no queuing.
REQ-029 Latency: START sampled at posedge N SHALL make DONE high in the cycle after posedge N+FRAME_LEN+2.

Reset
REQ-030 RST=1 SHALL, asynchronously, force state IDLE, HIT_CNT=0, ALARM=0, DONE=0, X_OUT=0, DET_RST=1, READY=1, and clear the shift register and bit counter.
REQ-031 RST mid-frame SHALL abandon the frame with no DONE pulse; operation SHALL resume from IDLE on the first posedge after RST falls.

Structure
REQ-032 A shared package SHALL hold FRAME_W, CNT_W and the state encoding constants (IDLE=3'b000 ... REPORT=3'b100).
REQ-033 The frame shift register and bit-down-counter SHALL be one sub-module, pattern_scan_shreg (load, shift enable, serial out, last-bit flag).

Verification
Bench model: 1001 overlapping detector, DET_HIT registered one cycle after the bit.
REQ-034 FRAME_IN=25'b1001_0011_0010_0001_0010_0100_1, LEN=25, THRESH=3 -> HIT_CNT=6, ALARM=1, DONE one cycle, 27 posedges after the START posedge.
REQ-035 FRAME_IN=25'b1001_0010_0100_1001_0010_0100_1, LEN=25, THRESH=7 -> 8 hits, HIT_CNT saturates at 7, ALARM=1.
REQ-036 Same frame as REQ-034, LEN=4, THRESH=2 -> HIT_CNT=1 (hit sampled in DRAIN), ALARM=0; LEN=0 -> DONE 2 posedges after START, HIT_CNT=0.
REQ-037 START pulsed during SHIFT -> ignored: one DONE only, READY=0 until IDLE.
REQ-038 RST asserted mid-SHIFT (asynchronous, between edges) -> immediately DET_RST=1, X_OUT=0, HIT_CNT=0, no DONE; next START completes normally.
